// File: rtl/reset_seq_pkg.sv
// Shared encodings for the reset sequencer: FSM states, reset-cause codes and a sizing helper.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    StHold    = 2'b00,
    StRelease = 2'b01,
    StRun     = 2'b10,
    StSoft    = 2'b11
  } state_e;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_SOFT = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-release chain; sync_ok rises SYNC_STAGES edges after reset_n deasserts.
module reset_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_out,
  input  logic reset_n,
  output logic sync_ok
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk_out or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign sync_ok = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged domain-reset sequencer with soft-reset handshake.
// Define RESET_SEQ_WDT_EN to add a watchdog that forces a soft reset when not kicked in RUN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned WDT_CYCLES  = 1024
) (
  input  logic                  clk_out,
  input  logic                  reset_n,
  input  logic                  soft_req,
  input  logic                  wdt_kick,
  output logic                  soft_ack,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  sys_ready,
  output logic [1:0]            cause
);

  localparam int unsigned CntW = $clog2(max3(HOLD_CYCLES, STAGE_GAP, WDT_CYCLES)) + 1;
  localparam int unsigned IdxW = $clog2(NUM_STAGES) + 1;

  logic sync_ok;

  reset_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_reset_sync (
    .clk_out(clk_out),
    .reset_n(reset_n),
    .sync_ok(sync_ok)
  );

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  rdy_q, rdy_d;
  logic                  ack_q, ack_d;
  logic [1:0]            cause_q, cause_d;
  logic                  armed_q, armed_d;

`ifdef RESET_SEQ_WDT_EN
  logic [CntW-1:0]       wdt_q, wdt_d;
`else
  logic                  unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    rdy_d   = rdy_q;
    ack_d   = 1'b0;
    cause_d = cause_q;
    // Re-arm only once the requester has dropped its level request.
    armed_d = armed_q | ~soft_req;
`ifdef RESET_SEQ_WDT_EN
    wdt_d   = '0;
`endif

    unique case (state_q)
      StHold: begin
        if (sync_ok) begin
          if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
            state_d = StRelease;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StRelease: begin
        if (cnt_q == CntW'(STAGE_GAP - 1)) begin
          cnt_d = '0;
          idx_d = idx_q + IdxW'(1);
          for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (idx_q == IdxW'(i)) rst_d[i] = 1'b1;
          end
          if (idx_q == IdxW'(NUM_STAGES - 1)) begin
            state_d = StRun;
            rdy_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (soft_req && armed_q) begin
          state_d = StSoft;
          rst_d   = '0;
          rdy_d   = 1'b0;
          ack_d   = 1'b1;
          armed_d = 1'b0;
          cause_d = CAUSE_SOFT;
        end
`ifdef RESET_SEQ_WDT_EN
        else if (!wdt_kick && (wdt_q == CntW'(WDT_CYCLES - 1))) begin
          state_d = StSoft;
          rst_d   = '0;
          rdy_d   = 1'b0;
          cause_d = CAUSE_WDT;
        end else begin
          wdt_d = wdt_kick ? '0 : wdt_q + CntW'(1);
        end
`endif
      end
      StSoft: begin
        state_d = StHold;
        cnt_d   = '0;
      end
      default: begin
        state_d = StHold;
      end
    endcase
  end

  always_ff @(posedge clk_out or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StHold;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      rdy_q   <= 1'b0;
      ack_q   <= 1'b0;
      cause_q <= CAUSE_POR;
      armed_q <= 1'b1;
`ifdef RESET_SEQ_WDT_EN
      wdt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      rdy_q   <= rdy_d;
      ack_q   <= ack_d;
      cause_q <= cause_d;
      armed_q <= armed_d;
`ifdef RESET_SEQ_WDT_EN
      wdt_q   <= wdt_d;
`endif
    end
  end

  assign soft_ack  = ack_q;
  assign rst_n_out = rst_q;
  assign sys_ready = rdy_q;
  assign cause     = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output-change events are queued per scenario
// and compared against changes observed on the DUT outputs.
module tb_reset_sequencer;

  localparam int unsigned SYNC = 2;
  localparam int unsigned HOLD = 16;
  localparam int unsigned NUM  = 3;
  localparam int unsigned GAP  = 4;
  localparam int unsigned WDT  = 1024;

  logic           clk_out  = 1'b0;
  logic           reset_n  = 1'b1;
  logic           soft_req = 1'b0;
  logic           wdt_kick = 1'b0;
  logic           soft_ack;
  logic [NUM-1:0] rst_n_out;
  logic           sys_ready;
  logic [1:0]     cause;

  always #5 clk_out = ~clk_out;

  reset_sequencer #(
    .SYNC_STAGES(SYNC),
    .HOLD_CYCLES(HOLD),
    .NUM_STAGES (NUM),
    .STAGE_GAP  (GAP),
    .WDT_CYCLES (WDT)
  ) dut (
    .clk_out  (clk_out),
    .reset_n  (reset_n),
    .soft_req (soft_req),
    .wdt_kick (wdt_kick),
    .soft_ack (soft_ack),
    .rst_n_out(rst_n_out),
    .sys_ready(sys_ready),
    .cause    (cause)
  );

  // k = number of rising edges since the scenario's reference point.
  typedef struct packed {
    int         k;
    logic [2:0] rst;
    logic       rdy;
    logic [1:0] cause;
    logic       ack;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic push_ev(input int k, input logic [2:0] r, input logic y, input logic [1:0] c,
                         input logic a);
    exp_q.push_back('{k: k, rst: r, rdy: y, cause: c, ack: a});
  endtask

  // Domain releases GAP apart after t0, sys_ready rising with the last one.
  task automatic push_seq(input int t0, input logic [1:0] c);
    for (int i = 0; i < int'(NUM); i++) begin
      push_ev(t0 + int'(GAP) * (i + 1), 3'((1 << (i + 1)) - 1), (i == int'(NUM) - 1), c, 1'b0);
    end
  endtask

  task automatic collect(input int n);
    ev_t prev, cur;
    prev = '{k: 0, rst: rst_n_out, rdy: sys_ready, cause: cause, ack: soft_ack};
    for (int k = 1; k <= n; k++) begin
      @(posedge clk_out);
      @(negedge clk_out);
      cur = '{k: k, rst: rst_n_out, rdy: sys_ready, cause: cause, ack: soft_ack};
      if ({cur.rst, cur.rdy, cur.cause, cur.ack} != {prev.rst, prev.rdy, prev.cause, prev.ack})
        obs_q.push_back(cur);
      prev = cur;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    checks += 4;
    if (rst_n_out !== 3'b000) begin
      errors++; $display("FAIL reset_rst: got %b required 000", rst_n_out);
    end
    if (sys_ready !== 1'b0) begin
      errors++; $display("FAIL reset_rdy: got %b required 0", sys_ready);
    end
    if (soft_ack !== 1'b0) begin
      errors++; $display("FAIL reset_ack: got %b required 0", soft_ack);
    end
    if (cause !== 2'b00) begin
      errors++; $display("FAIL reset_cause: got %b required 00", cause);
    end
    repeat (5) @(posedge clk_out);
    #1;
  endtask

  task automatic test_por_sequence();
    ev_t e, o;
    reset_n = 1'b1;
    push_seq(int'(SYNC + HOLD), 2'b00);
    collect(40);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL por_count: got %0d events required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL por_event: got none required k=%0d rst=%b", e.k, e.rst);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL por_event: got k=%0d rst=%b rdy=%b cause=%b ack=%b required k=%0d rst=%b rdy=%b cause=%b ack=%b",
                   o.k, o.rst, o.rdy, o.cause, o.ack, e.k, e.rst, e.rdy, e.cause, e.ack);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_soft_hold();
    ev_t e, o;
    @(posedge clk_out);
    #1 soft_req = 1'b1;
    push_ev(1, 3'b000, 1'b0, 2'b01, 1'b1);
    push_ev(2, 3'b000, 1'b0, 2'b01, 1'b0);
    push_seq(1 + 1 + int'(HOLD), 2'b01);
    fork
      collect(60);
      begin
        repeat (45) @(posedge clk_out);
        #1 soft_req = 1'b0;
      end
    join
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL soft_count: got %0d events required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL soft_event: got none required k=%0d rst=%b", e.k, e.rst);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL soft_event: got k=%0d rst=%b rdy=%b cause=%b ack=%b required k=%0d rst=%b rdy=%b cause=%b ack=%b",
                   o.k, o.rst, o.rdy, o.cause, o.ack, e.k, e.rst, e.rdy, e.cause, e.ack);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_async_mid_release();
    ev_t e, o;
    bit  found;
    @(posedge clk_out);
    #1 soft_req = 1'b1;
    @(posedge clk_out);
    #1 soft_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk_out);
      if (rst_n_out == 3'b001) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL async_reach_001: got rst=%b required 001 within 60 cycles", rst_n_out);
    end
    #2 reset_n = 1'b0;
    #1;
    checks += 4;
    if (rst_n_out !== 3'b000) begin
      errors++; $display("FAIL async_rst: got %b required 000", rst_n_out);
    end
    if (sys_ready !== 1'b0) begin
      errors++; $display("FAIL async_rdy: got %b required 0", sys_ready);
    end
    if (cause !== 2'b00) begin
      errors++; $display("FAIL async_cause: got %b required 00", cause);
    end
    if (soft_ack !== 1'b0) begin
      errors++; $display("FAIL async_ack: got %b required 0", soft_ack);
    end
    repeat (3) @(posedge clk_out);
    #1 reset_n = 1'b1;
    push_seq(int'(SYNC + HOLD), 2'b00);
    collect(40);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL async_count: got %0d events required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL async_event: got none required k=%0d rst=%b", e.k, e.rst);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL async_event: got k=%0d rst=%b rdy=%b cause=%b ack=%b required k=%0d rst=%b rdy=%b cause=%b ack=%b",
                   o.k, o.rst, o.rdy, o.cause, o.ack, e.k, e.rst, e.rdy, e.cause, e.ack);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_soft_in_hold();
    ev_t e, o;
    @(posedge clk_out);
    #1;
    reset_n  = 1'b0;
    soft_req = 1'b1;
    @(posedge clk_out);
    #1 reset_n = 1'b1;
    push_seq(int'(SYNC + HOLD), 2'b00);
    push_ev(31, 3'b000, 1'b0, 2'b01, 1'b1);
    push_ev(32, 3'b000, 1'b0, 2'b01, 1'b0);
    push_seq(31 + 1 + int'(HOLD), 2'b01);
    fork
      collect(70);
      begin
        repeat (32) @(posedge clk_out);
        #1 soft_req = 1'b0;
      end
    join
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL hold_req_count: got %0d events required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL hold_req_event: got none required k=%0d rst=%b", e.k, e.rst);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL hold_req_event: got k=%0d rst=%b rdy=%b cause=%b ack=%b required k=%0d rst=%b rdy=%b cause=%b ack=%b",
                   o.k, o.rst, o.rdy, o.cause, o.ack, e.k, e.rst, e.rdy, e.cause, e.ack);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_watchdog();
    ev_t e, o;
    // One kick gives a known zero point for the watchdog count.
    @(posedge clk_out);
    #1 wdt_kick = 1'b1;
    @(posedge clk_out);
    #1 wdt_kick = 1'b0;
`ifdef RESET_SEQ_WDT_EN
    push_ev(int'(WDT), 3'b000, 1'b0, 2'b10, 1'b0);
    push_seq(int'(WDT) + 1 + int'(HOLD), 2'b10);
    collect(int'(WDT) + 46);
    // Regular kicks keep the system running.
    @(posedge clk_out);
    #1 wdt_kick = 1'b1;
    @(posedge clk_out);
    #1 wdt_kick = 1'b0;
    fork
      collect(2100);
      repeat (2) begin
        repeat (999) @(posedge clk_out);
        #1 wdt_kick = 1'b1;
        @(posedge clk_out);
        #1 wdt_kick = 1'b0;
      end
    join
    // Soft request arriving on the expiry cycle takes priority.
    @(posedge clk_out);
    #1 wdt_kick = 1'b1;
    @(posedge clk_out);
    #1 wdt_kick = 1'b0;
    push_ev(int'(WDT), 3'b000, 1'b0, 2'b01, 1'b1);
    push_ev(int'(WDT) + 1, 3'b000, 1'b0, 2'b01, 1'b0);
    push_seq(int'(WDT) + 1 + int'(HOLD), 2'b01);
    fork
      collect(int'(WDT) + 36);
      begin
        repeat (int'(WDT) - 1) @(posedge clk_out);
        #1 soft_req = 1'b1;
        repeat (3) @(posedge clk_out);
        #1 soft_req = 1'b0;
      end
    join
`else
    collect(int'(WDT) + 76);
`endif
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL wdt_count: got %0d events required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL wdt_event: got none required k=%0d rst=%b", e.k, e.rst);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL wdt_event: got k=%0d rst=%b rdy=%b cause=%b ack=%b required k=%0d rst=%b rdy=%b cause=%b ack=%b",
                   o.k, o.rst, o.rdy, o.cause, o.ack, e.k, e.rst, e.rdy, e.cause, e.ack);
        end
      end
    end
    obs_q.delete();
    checks++;
    if (cause !== 2'b01) begin
      errors++; $display("FAIL wdt_final_cause: got %b required 01", cause);
    end
  endtask

  initial begin
    test_reset();
    test_por_sequence();
    test_soft_hold();
    test_async_mid_release();
    test_soft_in_hold();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
